// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR3 frame arbiter.
package ddr_arb_pkg;

  localparam int unsigned BEAT_BYTES = 16;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ARB  = 2'd1;
  localparam state_t S_CMD  = 2'd2;
  localparam state_t S_WAIT = 2'd3;

endpackage

// File: rtl/ddr3_frame_arbiter_if.sv
// Burst command handshake between the frame arbiter and the DDR3 AXI burst engine.
interface ddr3_frame_arbiter_if #(
  parameter int unsigned ADDR_W = 30
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              burst_done;
  logic              busy;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, busy,
    input  cmd_ready, burst_done
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, busy,
    output cmd_ready, burst_done
  );
endinterface

// File: rtl/ddr_addr_gen.sv
// Per-side burst address generator: wrap between begin/end, ping-pong bank, deferred restart.
module ddr_addr_gen #(
  parameter int unsigned ADDR_W      = 30,
  parameter int unsigned BURST_BYTES = 1024,
  parameter logic        INIT_BANK   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic              advance,
  input  logic              rst_req,
  input  logic              busy_side,
  input  logic              bank_load,
  input  logic              bank_val,
  output logic [ADDR_W-1:0] addr,
  output logic              bank,
  output logic              wrap
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bank_q, bank_d;
  logic              pend_q, pend_d;
  logic [ADDR_W:0]   next_addr;

  always_comb begin
    next_addr = {1'b0, addr_q} + (ADDR_W+1)'(BURST_BYTES);
    wrap      = advance && !pend_q && !rst_req && (next_addr >= {1'b0, e_addr});
    addr_d    = addr_q;
    bank_d    = bank_q;
    pend_d    = pend_q;
    if (init) begin
      addr_d = b_addr;
      bank_d = INIT_BANK;
      pend_d = 1'b0;
    end else begin
      // A restart requested while this side's burst is in flight lands on its completion.
      if (advance) begin
        pend_d = 1'b0;
        if (pend_q || rst_req || wrap) addr_d = b_addr;
        else                            addr_d = next_addr[ADDR_W-1:0];
      end else if (rst_req) begin
        if (busy_side) pend_d = 1'b1;
        else           addr_d = b_addr;
      end
      if (bank_load) bank_d = bank_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      bank_q <= INIT_BANK;
      pend_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
      pend_q <= pend_d;
    end
  end

  assign addr = addr_q;
  assign bank = bank_q;
endmodule

// File: rtl/ddr3_frame_arbiter.sv
// Round-robin scheduler of camera write / display read bursts onto one DDR3 burst engine.
module ddr3_frame_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 30,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned BURST_BYTES   = BURST_LEN * BEAT_BYTES,
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned RD_FIFO_DEPTH = 512,
  parameter int unsigned BANK_BIT      = 24
) (
  input  logic                 ui_clk,
  input  logic                 ui_rst,
  input  logic                 calib_done,
  input  logic                 pingpang,
  input  logic                 read_enable,
  input  logic [ADDR_W-1:0]    wr_b_addr,
  input  logic [ADDR_W-1:0]    wr_e_addr,
  input  logic [ADDR_W-1:0]    rd_b_addr,
  input  logic [ADDR_W-1:0]    rd_e_addr,
  input  logic                 wr_rst,
  input  logic                 rd_rst,
  input  logic [CNT_W-1:0]     wr_fifo_cnt,
  input  logic [CNT_W-1:0]     rd_fifo_cnt,
  ddr3_frame_arbiter_if.master cmd_if
);
  state_t            state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic              sel_wr_q, sel_wr_d;
  logic              hold_q, hold_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              busy_q, busy_d;

  logic              init, wr_elig, rd_elig, grant_wr;
  logic              wr_busy, rd_busy, wr_adv, rd_adv;
  logic              wr_wrap, rd_wrap, wr_bank, rd_bank;
  logic [ADDR_W-1:0] wr_addr, rd_addr, grant_addr;

  assign init    = (state_q == S_IDLE) && calib_done;
  assign wr_elig = wr_fifo_cnt >= CNT_W'(BURST_LEN);
  assign rd_elig = read_enable && (rd_fifo_cnt <= CNT_W'(RD_FIFO_DEPTH - BURST_LEN));
  assign grant_wr = wr_elig && (!rd_elig || !last_wr_q);
  assign wr_busy = ((state_q == S_CMD) || (state_q == S_WAIT)) && sel_wr_q;
  assign rd_busy = ((state_q == S_CMD) || (state_q == S_WAIT)) && !sel_wr_q;
  assign wr_adv  = (state_q == S_WAIT) && cmd_if.burst_done && sel_wr_q;
  assign rd_adv  = (state_q == S_WAIT) && cmd_if.burst_done && !sel_wr_q;

  ddr_addr_gen #(.ADDR_W(ADDR_W), .BURST_BYTES(BURST_BYTES), .INIT_BANK(1'b0)) u_wr_gen (
    .clk(ui_clk), .rst(ui_rst), .init(init), .b_addr(wr_b_addr), .e_addr(wr_e_addr),
    .advance(wr_adv), .rst_req(wr_rst), .busy_side(wr_busy),
    .bank_load(wr_wrap && pingpang), .bank_val(!wr_bank),
    .addr(wr_addr), .bank(wr_bank), .wrap(wr_wrap)
  );

  // On a write-frame wrap the display moves to the frame just completed.
  ddr_addr_gen #(.ADDR_W(ADDR_W), .BURST_BYTES(BURST_BYTES), .INIT_BANK(1'b1)) u_rd_gen (
    .clk(ui_clk), .rst(ui_rst), .init(init), .b_addr(rd_b_addr), .e_addr(rd_e_addr),
    .advance(rd_adv), .rst_req(rd_rst), .busy_side(rd_busy),
    .bank_load((wr_wrap && pingpang && !rd_busy) || rd_wrap),
    .bank_val(rd_wrap ? !wr_bank : wr_bank),
    .addr(rd_addr), .bank(rd_bank), .wrap(rd_wrap)
  );

  always_comb begin
    grant_addr = grant_wr ? wr_addr : rd_addr;
    if (pingpang && (grant_wr ? wr_bank : rd_bank)) grant_addr[BANK_BIT] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    sel_wr_d    = sel_wr_q;
    hold_d      = hold_q;
    cmd_valid_d = cmd_valid_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: if (calib_done) state_d = S_ARB;
      S_ARB: begin
        // One settle cycle after a burst so the fill counts reflect the completed transfer.
        if (hold_q) begin
          hold_d = 1'b0;
        end else if (wr_elig || rd_elig) begin
          state_d     = S_CMD;
          cmd_valid_d = 1'b1;
          cmd_wr_d    = grant_wr;
          cmd_addr_d  = grant_addr;
          sel_wr_d    = grant_wr;
          last_wr_d   = grant_wr;
        end
      end
      S_CMD: if (cmd_if.cmd_ready) begin
        state_d     = S_WAIT;
        cmd_valid_d = 1'b0;
        busy_d      = 1'b1;
      end
      S_WAIT: if (cmd_if.burst_done) begin
        state_d = S_ARB;
        busy_d  = 1'b0;
        hold_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (!calib_done) begin
      state_d     = S_IDLE;
      cmd_valid_d = 1'b0;
      busy_d      = 1'b0;
      hold_d      = 1'b0;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      state_q     <= S_IDLE;
      last_wr_q   <= 1'b0;
      sel_wr_q    <= 1'b0;
      hold_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      sel_wr_q    <= sel_wr_d;
      hold_q      <= hold_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd_wr    = cmd_wr_q;
  assign cmd_if.cmd_addr  = cmd_addr_q;
  assign cmd_if.cmd_len   = 8'(BURST_LEN - 1);
  assign cmd_if.busy      = busy_q;
endmodule

// File: tb/tb_ddr3_frame_arbiter.sv
// Randomized self-checking bench for ddr3_frame_arbiter against a frame-level reference model.
module tb_ddr3_frame_arbiter;
  localparam int unsigned ADDR_W = 30;
  localparam logic [63:0] BANK_MASK = 64'h100_0000;

  logic              ui_clk = 1'b0;
  logic              ui_rst = 1'b1;
  logic              calib_done = 1'b0;
  logic              pingpang = 1'b1;
  logic              read_enable = 1'b0;
  logic [ADDR_W-1:0] wr_b_addr = 30'h0;
  logic [ADDR_W-1:0] wr_e_addr = 30'd8192;
  logic [ADDR_W-1:0] rd_b_addr = 30'h2000;
  logic [ADDR_W-1:0] rd_e_addr = 30'h3400;
  logic              wr_rst = 1'b0;
  logic              rd_rst = 1'b0;
  logic [9:0]        wr_fifo_cnt = '0;
  logic [9:0]        rd_fifo_cnt = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [ADDR_W-1:0] last_cmd_addr;

  // Reference model state: per-side offset, bank, pending restart, and who was served last.
  logic [63:0] m_wr_addr, m_rd_addr;
  bit m_wr_bank, m_rd_bank, m_wr_pend, m_rd_pend, m_last_wr;

  ddr3_frame_arbiter_if #(.ADDR_W(ADDR_W)) cmd_if ();

  ddr3_frame_arbiter #(.ADDR_W(ADDR_W)) dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst), .calib_done(calib_done), .pingpang(pingpang),
    .read_enable(read_enable), .wr_b_addr(wr_b_addr), .wr_e_addr(wr_e_addr),
    .rd_b_addr(rd_b_addr), .rd_e_addr(rd_e_addr), .wr_rst(wr_rst), .rd_rst(rd_rst),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt), .cmd_if(cmd_if.master)
  );

  always #4 ui_clk = ~ui_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_wr_addr = 64'(wr_b_addr);
    m_rd_addr = 64'(rd_b_addr);
    m_wr_bank = 1'b0;
    m_rd_bank = 1'b1;
    m_wr_pend = 1'b0;
    m_rd_pend = 1'b0;
    m_last_wr = 1'b0;
  endfunction

  function automatic void m_complete(input bit is_wr);
    logic [63:0] nxt;
    if (is_wr) begin
      nxt = m_wr_addr + 64'd1024;
      if (m_wr_pend) begin
        m_wr_addr = 64'(wr_b_addr);
        m_wr_pend = 1'b0;
      end else if (nxt >= 64'(wr_e_addr)) begin
        m_wr_addr = 64'(wr_b_addr);
        if (pingpang) begin
          m_rd_bank = m_wr_bank;
          m_wr_bank = !m_wr_bank;
        end
      end else begin
        m_wr_addr = nxt;
      end
    end else begin
      nxt = m_rd_addr + 64'd1024;
      if (m_rd_pend) begin
        m_rd_addr = 64'(rd_b_addr);
        m_rd_pend = 1'b0;
      end else if (nxt >= 64'(rd_e_addr)) begin
        m_rd_addr = 64'(rd_b_addr);
        m_rd_bank = !m_wr_bank;
      end else begin
        m_rd_addr = nxt;
      end
    end
  endfunction

  function automatic logic [9:0] pick(input int unsigned lo, input int unsigned hi);
    int unsigned r;
    r = $urandom_range(3);
    if (r == 0) return 10'(lo);
    if (r == 1) return 10'(hi);
    return 10'($urandom_range(hi, lo));
  endfunction

  task automatic set_counts(input bit we, input bit re);
    wr_fifo_cnt = we ? pick(64, 1023) : pick(0, 63);
    if (re) begin
      read_enable = 1'b1;
      rd_fifo_cnt = pick(0, 448);
    end else if ($urandom_range(1) == 1) begin
      read_enable = 1'b0;
      rd_fifo_cnt = pick(0, 1023);
    end else begin
      read_enable = 1'b1;
      rd_fifo_cnt = pick(449, 1023);
    end
  endtask

  // Neither side eligible: no command may appear; a stray burst_done must be ignored.
  task automatic idle_check(input int cycles);
    set_counts(1'b0, 1'b0);
    for (int i = 0; i < cycles; i++) begin
      cmd_if.burst_done = (i == 0);
      @(negedge ui_clk);
      chk("no_grant", 64'(cmd_if.cmd_valid), 64'd0);
    end
    cmd_if.burst_done = 1'b0;
  endtask

  task automatic burst(input bit we, input bit re, input int exp_lat, input int rdy_dly,
                       input int done_dly, input int rst_sel);
    bit exp_wr;
    logic [63:0] exp_addr;
    int n;
    set_counts(we, re);
    exp_wr   = (we && re) ? !m_last_wr : we;
    exp_addr = exp_wr ? m_wr_addr : m_rd_addr;
    if (pingpang && (exp_wr ? m_wr_bank : m_rd_bank)) exp_addr = exp_addr | BANK_MASK;
    n = 0;
    while (cmd_if.cmd_valid !== 1'b1 && n < 40) begin
      @(negedge ui_clk);
      n++;
    end
    chk("cmd_valid_seen", 64'(cmd_if.cmd_valid), 64'd1);
    if (cmd_if.cmd_valid !== 1'b1) return;
    if (exp_lat >= 0) chk("grant_latency", 64'(n), 64'(exp_lat));
    chk("cmd_wr", 64'(cmd_if.cmd_wr), 64'(exp_wr));
    chk("cmd_addr", 64'(cmd_if.cmd_addr), exp_addr);
    chk("cmd_len", 64'(cmd_if.cmd_len), 64'd63);
    last_cmd_addr = cmd_if.cmd_addr;
    m_last_wr = exp_wr;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge ui_clk);
      chk("hold_valid", 64'(cmd_if.cmd_valid), 64'd1);
      chk("hold_addr", 64'(cmd_if.cmd_addr), exp_addr);
      chk("hold_busy", 64'(cmd_if.busy), 64'd0);
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge ui_clk);
    cmd_if.cmd_ready = 1'b0;
    chk("valid_drop", 64'(cmd_if.cmd_valid), 64'd0);
    chk("busy_rise", 64'(cmd_if.busy), 64'd1);
    if (rst_sel != 0) begin
      if (rst_sel == 1) wr_rst = 1'b1;
      else              rd_rst = 1'b1;
      @(negedge ui_clk);
      wr_rst = 1'b0;
      rd_rst = 1'b0;
      if ((rst_sel == 1) == exp_wr) begin
        if (exp_wr) m_wr_pend = 1'b1;
        else        m_rd_pend = 1'b1;
      end else if (rst_sel == 1) begin
        m_wr_addr = 64'(wr_b_addr);
      end else begin
        m_rd_addr = 64'(rd_b_addr);
      end
    end
    for (int i = 0; i < done_dly; i++) @(negedge ui_clk);
    cmd_if.burst_done = 1'b1;
    @(negedge ui_clk);
    cmd_if.burst_done = 1'b0;
    m_complete(exp_wr);
    chk("busy_fall", 64'(cmd_if.busy), 64'd0);
  endtask

  initial begin
    bit we, re;
    int lat;
    cmd_if.cmd_ready  = 1'b0;
    cmd_if.burst_done = 1'b0;
    repeat (3) @(negedge ui_clk);
    ui_rst = 1'b0;
    @(negedge ui_clk);
    chk("rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
    chk("rst_wr", 64'(cmd_if.cmd_wr), 64'd0);
    chk("rst_addr", 64'(cmd_if.cmd_addr), 64'd0);
    chk("rst_len", 64'(cmd_if.cmd_len), 64'd63);
    chk("rst_busy", 64'(cmd_if.busy), 64'd0);

    wr_fifo_cnt = 10'd64;
    read_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ui_clk);
      chk("uncalibrated_idle", 64'(cmd_if.cmd_valid), 64'd0);
    end

    m_reset();
    calib_done = 1'b1;
    burst(1'b1, 1'b0, 2, 0, 1, 0);
    chk("first_wr_addr", 64'(last_cmd_addr), 64'd0);
    burst(1'b1, 1'b0, 2, 0, 2, 0);
    chk("second_wr_addr", 64'(last_cmd_addr), 64'd1024);

    for (int i = 0; i < 4; i++) burst(1'b1, 1'b1, 2, 0, 1, 0);
    burst(1'b1, 1'b1, 2, 20, 1, 0);

    burst(1'b1, 1'b0, 2, 0, 2, 1);
    burst(1'b1, 1'b0, 2, 0, 1, 0);
    chk("wr_rst_restart", 64'(last_cmd_addr & ~30'h100_0000), 64'(wr_b_addr));
    burst(1'b1, 1'b0, 2, 0, 2, 2);

    idle_check(4);
    burst(1'b1, 1'b1, 1, 0, 1, 0);

    for (int k = 0; k < 250; k++) begin
      we  = 1'($urandom_range(1));
      re  = 1'($urandom_range(1));
      lat = 2;
      if (!we && !re) begin
        idle_check(3);
        lat = 1;
        we  = 1'b1;
      end
      burst(we, re, lat, int'($urandom_range(3)), int'($urandom_range(4)),
            ($urandom_range(9) == 0) ? int'($urandom_range(2, 1)) : 0);
    end

    set_counts(1'b1, 1'b1);
    for (int i = 0; i < 40 && cmd_if.cmd_valid !== 1'b1; i++) @(negedge ui_clk);
    chk("pre_reset_valid", 64'(cmd_if.cmd_valid), 64'd1);
    cmd_if.cmd_ready = 1'b1;
    @(negedge ui_clk);
    cmd_if.cmd_ready = 1'b0;
    ui_rst = 1'b1;
    @(negedge ui_clk);
    chk("midburst_rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
    chk("midburst_rst_busy", 64'(cmd_if.busy), 64'd0);
    ui_rst = 1'b0;
    m_reset();
    burst(1'b1, 1'b1, 2, 0, 1, 0);
    chk("post_reset_addr", 64'(last_cmd_addr), 64'(wr_b_addr));

    wr_e_addr = 30'd614400;
    ui_rst = 1'b1;
    @(negedge ui_clk);
    ui_rst = 1'b0;
    m_reset();
    for (int i = 0; i < 600; i++) burst(1'b1, 1'b0, 2, 0, 0, 0);
    burst(1'b1, 1'b0, 2, 0, 0, 0);
    chk("wrap_addr", 64'(last_cmd_addr), 64'h100_0000);
    burst(1'b0, 1'b1, 2, 0, 0, 0);
    chk("rd_bank_after_wrap", 64'(last_cmd_addr), 64'(rd_b_addr));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
